multicycle_sequencer: RTL and testbench

Decode-stage controller that sequences the multi-cycle stack instructions (CALL, RET, RTI) and hardware interrupt entry, replacing separate per-instruction call/interrupt FSMs with one arbitrated state machine. It sits beside the control unit in decode. It consumes one-cycle decode pulses and the external interrupt pin, and drives the pipeline stall, second-iteration, flush and forced push/pop signals into the decode output bundle. A memory-ready handshake lets the stack accesses wait on the memory stage.

---
 rtl/decode_defs.sv | 30 +++
 rtl/multicycle_sequencer_if.sv | 43 ++++
 rtl/int_edge_latch.sv | 48 ++++
 rtl/multicycle_sequencer.sv | 142 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/decode_defs.sv
// Shared definitions for the decode-stage multi-cycle sequencer.
// Holds the sequencer state and sequence-kind encodings, the default
// number of 16-bit stack words per saved PC, the stack word width, and
// a helper that sizes the word-select field.
package decode_defs;

    localparam int PC_WORDS_DEFAULT = 2;
    localparam int STACK_WORD_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PUSH_PC    = 3'd1,
        ST_PUSH_FLAGS = 3'd2,
        ST_POP_FLAGS  = 3'd3,
        ST_POP_PC     = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        KIND_CALL = 2'd0,
        KIND_INT  = 2'd1,
        KIND_RET  = 2'd2,
        KIND_RTI  = 2'd3
    } seq_kind_e;

    // Width of the PC word index; a single-word PC still gets one bit.
    function automatic int word_sel_width(input int pc_words);
        return (pc_words > 1) ? $clog2(pc_words) : 1;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Decode-side bundle between the control unit and the multi-cycle sequencer.
// Inputs to the sequencer: DecValid, CallDec, RetDec, RtiDec (decode pulses),
// IntIn (interrupt pin), MemReady (memory stage accepts the stack access).
// Outputs from the sequencer: Stall, SecondIter, Flush, ForcePush, ForcePop,
// FlagSave, FlagRestore, WordSel, IntAck, Busy.
// The master modport is the decode/pipeline side, slave is the sequencer.
interface multicycle_sequencer_if #(
    parameter int PC_WORDS = decode_defs::PC_WORDS_DEFAULT
);
    import decode_defs::*;

    localparam int WSW = word_sel_width(PC_WORDS);

    logic           DecValid;
    logic           CallDec;
    logic           RetDec;
    logic           RtiDec;
    logic           IntIn;
    logic           MemReady;
    logic           Stall;
    logic           SecondIter;
    logic           Flush;
    logic           ForcePush;
    logic           ForcePop;
    logic           FlagSave;
    logic           FlagRestore;
    logic [WSW-1:0] WordSel;
    logic           IntAck;
    logic           Busy;

    modport master (
        output DecValid, CallDec, RetDec, RtiDec, IntIn, MemReady,
        input  Stall, SecondIter, Flush, ForcePush, ForcePop,
               FlagSave, FlagRestore, WordSel, IntAck, Busy
    );

    modport slave (
        input  DecValid, CallDec, RetDec, RtiDec, IntIn, MemReady,
        output Stall, SecondIter, Flush, ForcePush, ForcePop,
               FlagSave, FlagRestore, WordSel, IntAck, Busy
    );

endinterface

// File: rtl/int_edge_latch.sv
// Rising-edge detector and single-entry pending latch for the interrupt pin.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   int_in  - interrupt pin (level)
//   clear   - drop the pending interrupt (interrupt entry acknowledged)
//   pending - an interrupt is waiting to be taken
module int_edge_latch
    import decode_defs::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic int_in,
    input  logic clear,
    output logic pending
);

    logic int_prev_q, int_prev_d;
    logic int_pend_q, int_pend_d;
    logic rise;

    // A fresh edge wins over a clear in the same cycle, so an interrupt
    // arriving exactly on the acknowledge cycle is not lost. Edges seen
    // while already pending simply keep the bit set.
    always_comb begin
        rise       = int_in && !int_prev_q;
        int_prev_d = int_in;
        int_pend_d = int_pend_q;
        if (rise) begin
            int_pend_d = 1'b1;
        end else if (clear) begin
            int_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_prev_q <= 1'b0;
            int_pend_q <= 1'b0;
        end else begin
            int_prev_q <= int_prev_d;
            int_pend_q <= int_pend_d;
        end
    end

    assign pending = int_pend_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Decode-stage sequencer for CALL, RET, RTI and hardware interrupt entry.
// One arbitrated FSM drives the stall, continuation, flush and forced
// push/pop controls, waiting on MemReady for each stack access.
// Ports:
//   Clk - clock
//   Rst - asynchronous active-low reset
//   bus - multicycle_sequencer_if slave modport (decode pulses, interrupt
//         pin and memory handshake in; pipeline controls out)
module multicycle_sequencer
    import decode_defs::*;
#(
    parameter int PC_WORDS = PC_WORDS_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Rst,
    multicycle_sequencer_if.slave bus
);

    localparam int             WSW       = word_sel_width(PC_WORDS);
    localparam logic [WSW-1:0] LAST_WORD = WSW'(PC_WORDS - 1);

    seq_state_e     state_q, state_d;
    seq_kind_e      kind_q, kind_d;
    logic [WSW-1:0] cnt_q, cnt_d;

    logic int_pend;
    logic int_ack;
    logic last_word;
    logic busy;
    logic first_cycle;
    logic last_step;
    logic flush;

    int_edge_latch u_int_edge (
        .clk     (Clk),
        .rst_n   (Rst),
        .int_in  (bus.IntIn),
        .clear   (int_ack),
        .pending (int_pend)
    );

    // Next state. Nothing advances without MemReady; the counter is cleared
    // whenever a PC state is entered or left so WordSel is 0 outside it.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        last_word = (cnt_q == LAST_WORD);
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.DecValid && bus.RtiDec) begin
                    state_d = ST_POP_FLAGS;
                    kind_d  = KIND_RTI;
                end else if (bus.DecValid && bus.RetDec) begin
                    state_d = ST_POP_PC;
                    kind_d  = KIND_RET;
                end else if (bus.DecValid && bus.CallDec) begin
                    state_d = ST_PUSH_PC;
                    kind_d  = KIND_CALL;
                end else if (int_pend) begin
                    state_d = ST_PUSH_PC;
                    kind_d  = KIND_INT;
                end
            end
            ST_PUSH_PC: begin
                if (bus.MemReady) begin
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = (kind_q == KIND_INT) ? ST_PUSH_FLAGS : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + WSW'(1);
                    end
                end
            end
            ST_PUSH_FLAGS: begin
                if (bus.MemReady) begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP_FLAGS: begin
                if (bus.MemReady) begin
                    cnt_d   = '0;
                    state_d = ST_POP_PC;
                end
            end
            ST_POP_PC: begin
                if (bus.MemReady) begin
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + WSW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_CALL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

    // The opening cycle of a sequence is either the first PC push, the
    // flags pop of RTI, or the first PC pop of a plain RET. The closing
    // step is the flags push for INT and the last PC word otherwise.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        first_cycle = ((state_q == ST_PUSH_PC) && (cnt_q == '0))
                   || (state_q == ST_POP_FLAGS)
                   || ((state_q == ST_POP_PC) && (cnt_q == '0) && (kind_q == KIND_RET));
        last_step   = ((state_q == ST_PUSH_PC) && last_word && (kind_q == KIND_CALL))
                   || (state_q == ST_PUSH_FLAGS)
                   || ((state_q == ST_POP_PC) && last_word);
        flush       = last_step && bus.MemReady;
        int_ack     = flush && (kind_q == KIND_INT);
    end

    assign bus.Busy        = busy;
    assign bus.Stall       = busy && !flush;
    assign bus.SecondIter  = busy && !first_cycle;
    assign bus.Flush       = flush;
    assign bus.IntAck      = int_ack;
    assign bus.ForcePush   = (state_q == ST_PUSH_PC) || (state_q == ST_PUSH_FLAGS);
    assign bus.ForcePop    = (state_q == ST_POP_FLAGS) || (state_q == ST_POP_PC);
    assign bus.FlagSave    = (state_q == ST_PUSH_FLAGS);
    assign bus.FlagRestore = (state_q == ST_POP_FLAGS);
    assign bus.WordSel     = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer with PC_WORDS=2.
// A table of per-cycle {stimulus, expected outputs} drives most checks;
// hand-written sequences cover reset behaviour around interrupt entry.
// Stimulus bits:  {DecValid, CallDec, RetDec, RtiDec, IntIn, MemReady}
// Expected bits:  {Busy, Stall, SecondIter, Flush, ForcePush, ForcePop,
//                  FlagSave, FlagRestore, IntAck, WordSel}
module tb_multicycle_sequencer;

    logic clk;
    logic rst_n;

    multicycle_sequencer_if #(.PC_WORDS(2)) bus ();

    multicycle_sequencer #(.PC_WORDS(2)) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus.slave)
    );

    typedef struct {
        string      name;
        logic [5:0] stim;
        logic [9:0] expOut;
    } vec_t;

    localparam logic [5:0] I_NOP      = 6'b000001;
    localparam logic [5:0] I_WAIT     = 6'b000000;
    localparam logic [5:0] I_CALL     = 6'b110001;
    localparam logic [5:0] I_RET      = 6'b101001;
    localparam logic [5:0] I_RTI      = 6'b100101;
    localparam logic [5:0] I_ALL      = 6'b111101;
    localparam logic [5:0] I_INVALID  = 6'b011101;
    localparam logic [5:0] I_INT      = 6'b000011;
    localparam logic [5:0] I_CALL_INT = 6'b110011;

    localparam logic [9:0] O_IDLE       = 10'b0000000000;
    localparam logic [9:0] O_PUSH0      = 10'b1100100000;
    localparam logic [9:0] O_CALL_LAST  = 10'b1011100001;
    localparam logic [9:0] O_INT_PUSH1  = 10'b1110100001;
    localparam logic [9:0] O_INT_FLAGS  = 10'b1011101010;
    localparam logic [9:0] O_FLAGS_WAIT = 10'b1110101000;
    localparam logic [9:0] O_RTI_FLAGS  = 10'b1100010100;
    localparam logic [9:0] O_RTI_POP0   = 10'b1110010000;
    localparam logic [9:0] O_RET_POP0   = 10'b1100010000;
    localparam logic [9:0] O_POP1_WAIT  = 10'b1110010001;
    localparam logic [9:0] O_POP_LAST   = 10'b1011010001;

    vec_t vecs[$];
    int   vecCount  = 0;
    int   missCount = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upper bound on total run time so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input string n, input logic [5:0] s, input logic [9:0] e);
        vec_t v;
        v.name   = n;
        v.stim   = s;
        v.expOut = e;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [5:0] s);
        {bus.DecValid, bus.CallDec, bus.RetDec, bus.RtiDec, bus.IntIn, bus.MemReady} = s;
    endtask

    task automatic checkOutput(input string n, input logic [9:0] e);
        logic [9:0] act;
        act = {bus.Busy, bus.Stall, bus.SecondIter, bus.Flush, bus.ForcePush,
               bus.ForcePop, bus.FlagSave, bus.FlagRestore, bus.IntAck, bus.WordSel};
        vecCount++;
        if (act !== e) begin
            missCount++;
            $display("[TB] FAIL %s: actual=%b required=%b", n, act, e);
        end
    endtask

    task automatic runCycle(input string n, input logic [5:0] s, input logic [9:0] e);
        @(negedge clk);
        applyStimulus(s);
        #1;
        checkOutput(n, e);
    endtask

    initial begin
        // CALL, then RTI
        addVec("idle0",      I_NOP,      O_IDLE);
        addVec("callDec",    I_CALL,     O_IDLE);
        addVec("callPush0",  I_NOP,      O_PUSH0);
        addVec("callPush1",  I_NOP,      O_CALL_LAST);
        addVec("callDone",   I_NOP,      O_IDLE);
        addVec("rtiDec",     I_RTI,      O_IDLE);
        addVec("rtiFlags",   I_NOP,      O_RTI_FLAGS);
        addVec("rtiPop0",    I_NOP,      O_RTI_POP0);
        addVec("rtiPop1",    I_NOP,      O_POP_LAST);
        addVec("rtiDone",    I_NOP,      O_IDLE);
        // RET with MemReady low on the second word
        addVec("retDec",     I_RET,      O_IDLE);
        addVec("retPop0",    I_NOP,      O_RET_POP0);
        addVec("retWait0",   I_WAIT,     O_POP1_WAIT);
        addVec("retWait1",   I_WAIT,     O_POP1_WAIT);
        addVec("retWait2",   I_WAIT,     O_POP1_WAIT);
        addVec("retPop1",    I_NOP,      O_POP_LAST);
        addVec("retDone",    I_NOP,      O_IDLE);
        // interrupt edge together with CALL: CALL first, one idle, then INT
        addVec("ciDec",      I_CALL_INT, O_IDLE);
        addVec("ciCall0",    I_INT,      O_PUSH0);
        addVec("ciCall1",    I_INT,      O_CALL_LAST);
        addVec("ciGap",      I_INT,      O_IDLE);
        addVec("ciInt0",     I_INT,      O_PUSH0);
        addVec("ciInt1",     I_INT,      O_INT_PUSH1);
        addVec("ciIntFlags", I_INT,      O_INT_FLAGS);
        addVec("ciDone",     I_NOP,      O_IDLE);
        addVec("ciNoRepeat", I_NOP,      O_IDLE);
        // simultaneous pulses resolve to RTI
        addVec("allDec",     I_ALL,      O_IDLE);
        addVec("allFlags",   I_NOP,      O_RTI_FLAGS);
        addVec("allPop0",    I_NOP,      O_RTI_POP0);
        addVec("allPop1",    I_NOP,      O_POP_LAST);
        addVec("allDone",    I_NOP,      O_IDLE);
        // pulses without DecValid are ignored
        addVec("invDec",     I_INVALID,  O_IDLE);
        addVec("invIdle",    I_NOP,      O_IDLE);
        // RET pulse while busy is ignored
        addVec("busyDec",    I_CALL,     O_IDLE);
        addVec("busyPush0",  I_RET,      O_PUSH0);
        addVec("busyPush1",  I_NOP,      O_CALL_LAST);
        addVec("busyDone0",  I_NOP,      O_IDLE);
        addVec("busyDone1",  I_NOP,      O_IDLE);
        // two interrupt edges during CALL give a single INT
        addVec("dblDec",     I_CALL,     O_IDLE);
        addVec("dblPush0",   I_INT,      O_PUSH0);
        addVec("dblPush1",   I_NOP,      O_CALL_LAST);
        addVec("dblGap",     I_INT,      O_IDLE);
        addVec("dblInt0",    I_NOP,      O_PUSH0);
        addVec("dblInt1",    I_NOP,      O_INT_PUSH1);
        addVec("dblIntFlg",  I_NOP,      O_INT_FLAGS);
        addVec("dblIdle0",   I_NOP,      O_IDLE);
        addVec("dblIdle1",   I_NOP,      O_IDLE);
        addVec("dblIdle2",   I_NOP,      O_IDLE);
        // edge on the acknowledge cycle re-arms the interrupt
        addVec("ackEdge",    I_INT,      O_IDLE);
        addVec("ackPend",    I_NOP,      O_IDLE);
        addVec("ackInt0",    I_NOP,      O_PUSH0);
        addVec("ackInt1",    I_NOP,      O_INT_PUSH1);
        addVec("ackFlgWait", I_WAIT,     O_FLAGS_WAIT);
        addVec("ackFlgDone", I_INT,      O_INT_FLAGS);
        addVec("ackRePend",  I_INT,      O_IDLE);
        addVec("ackReInt0",  I_NOP,      O_PUSH0);
        addVec("ackReInt1",  I_NOP,      O_INT_PUSH1);
        addVec("ackReFlags", I_NOP,      O_INT_FLAGS);
        addVec("ackIdle0",   I_NOP,      O_IDLE);
        addVec("ackIdle1",   I_NOP,      O_IDLE);

        rst_n = 1'b0;
        applyStimulus(I_WAIT);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetState", O_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            runCycle(vecs[i].name, vecs[i].stim, vecs[i].expOut);
        end

        // reset in the middle of interrupt entry
        runCycle("rstEdge",  I_INT, O_IDLE);
        runCycle("rstPend",  I_NOP, O_IDLE);
        runCycle("rstInt0",  I_NOP, O_PUSH0);
        @(negedge clk);
        applyStimulus(I_NOP);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstAsync", O_IDLE);
        @(negedge clk);
        #1;
        checkOutput("rstHold", O_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(I_NOP);
        #1;
        checkOutput("rstRel", O_IDLE);
        for (int i = 0; i < 4; i++) begin
            runCycle("rstNoAck", I_NOP, O_IDLE);
        end

        // IntIn already high when reset is released
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(I_INT);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("relHigh0", O_IDLE);
        runCycle("relHighPend",  I_INT, O_IDLE);
        runCycle("relHighInt0",  I_INT, O_PUSH0);
        runCycle("relHighInt1",  I_INT, O_INT_PUSH1);
        runCycle("relHighFlags", I_INT, O_INT_FLAGS);
        runCycle("relHighIdle0", I_INT, O_IDLE);
        runCycle("relHighIdle1", I_NOP, O_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
